// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the CDB arbiter slice.
//   NUM_SRC producers (0=ALU, 1=LSB load, 2=store-ready), FIFO_DEPTH entries each,
//   ROB_LOG-bit RobId, cdb_entry_t = {value, topc, robid} payload.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_SRC    = 3;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned ROB_LOG    = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SRC_W      = 2;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    localparam logic [SRC_W-1:0]  CDB_SRC_ALU = SRC_W'(0);
    localparam logic [SRC_W-1:0]  CDB_SRC_LSB = SRC_W'(1);
    localparam logic [SRC_W-1:0]  CDB_SRC_ST  = SRC_W'(2);
    localparam logic [DATA_W-1:0] NO_JUMP_PC  = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [DATA_W-1:0]  value;
        logic [DATA_W-1:0]  topc;
        logic [ROB_LOG-1:0] robid;
    } cdb_entry_t;

    // Source index k steps after base, modulo NUM_SRC.
    function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] base, input int unsigned k);
        return SRC_W'((int'(base) + k) % NUM_SRC);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the CDB arbiter.
//   slave  : used by the arbiter (takes src_*, drives src_ready and cdb_*)
//   master : used by producers / bench (drives src_*, observes src_ready and cdb_*)
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic [NUM_SRC-1:0]         src_valid;
    logic [NUM_SRC-1:0]         src_ready;
    logic [NUM_SRC*DATA_W-1:0]  src_value;
    logic [NUM_SRC*DATA_W-1:0]  src_topc;
    logic [NUM_SRC*ROB_LOG-1:0] src_robid;
    logic                       cdb_valid;
    logic [SRC_W-1:0]           cdb_src;
    logic [DATA_W-1:0]          cdb_value;
    logic [DATA_W-1:0]          cdb_topc;
    logic [ROB_LOG-1:0]         cdb_robid;

    modport slave (
        input  src_valid, src_value, src_topc, src_robid,
        output src_ready, cdb_valid, cdb_src, cdb_value, cdb_topc, cdb_robid
    );

    modport master (
        output src_valid, src_value, src_topc, src_robid,
        input  src_ready, cdb_valid, cdb_src, cdb_value, cdb_topc, cdb_robid
    );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-producer skid FIFO holding {value, topc, robid}.
//   clk, rst : clock, async active-high reset
//   flush    : synchronous discard of all entries
//   push/pop : pre-qualified by the caller (never push when full, never pop when empty)
//   din/dout : payload in, head payload out
//   full/empty : derived from the registered count only
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t din,
    output cdb_entry_t dout,
    output logic       full,
    output logic       empty
);

    cdb_entry_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset; an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB between the write-back producers.
//   clk, rst : clock, async active-high reset
//   rdy      : global enable (low pauses push, pop and CDB update)
//   flush    : ROB jump flag; empties every FIFO and drops the broadcast
//   bus      : producer inputs/ready and the registered cdb_* broadcast
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    cdb_entry_t         din  [NUM_SRC];
    cdb_entry_t         head [NUM_SRC];

    logic               gnt_valid;
    logic [SRC_W-1:0]   gnt_idx;
    logic [SRC_W-1:0]   cand;
    logic [NUM_SRC-1:0] gnt_oh;

    logic               cdb_valid_q;
    logic [SRC_W-1:0]   cdb_src_q;
    cdb_entry_t         cdb_q;
    logic [SRC_W-1:0]   rr_last;

    // One FIFO per producer; push needs registered space, rdy and no flush.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign din[gi].value = bus.src_value[gi*DATA_W +: DATA_W];
        assign din[gi].topc  = bus.src_topc[gi*DATA_W +: DATA_W];
        assign din[gi].robid = bus.src_robid[gi*ROB_LOG +: ROB_LOG];
        assign push[gi]      = bus.src_valid[gi] & ~full[gi] & rdy & ~flush;

        cdb_src_fifo u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[gi]),
            .pop   (pop[gi]),
            .din   (din[gi]),
            .dout  (head[gi]),
            .full  (full[gi]),
            .empty (empty[gi])
        );
    end

    // Round-robin pick: first non-empty FIFO after rr_last, from registered state only.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        gnt_oh    = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = rr_next(rr_last, k);
            if (!gnt_valid && !empty[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (gnt_valid) gnt_oh[gnt_idx] = 1'b1;
    end

    assign pop = gnt_oh & {NUM_SRC{rdy & ~flush}};

    // Broadcast register and round-robin pointer; flush beats a stalled rdy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
            cdb_q.value <= '0;
            cdb_q.topc  <= NO_JUMP_PC;
            cdb_q.robid <= '0;
            rr_last     <= SRC_W'(NUM_SRC - 1);
        end else if (flush) begin
            cdb_valid_q <= 1'b0;
        end else if (rdy) begin
            if (gnt_valid) begin
                cdb_valid_q <= 1'b1;
                cdb_src_q   <= gnt_idx;
                cdb_q       <= head[gnt_idx];
                rr_last     <= gnt_idx;
            end else begin
                cdb_valid_q <= 1'b0;
            end
        end
    end

    assign bus.src_ready = ~full & {NUM_SRC{rdy}};
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_src   = cdb_src_q;
    assign bus.cdb_value = cdb_q.value;
    assign bus.cdb_topc  = cdb_q.topc;
    assign bus.cdb_robid = cdb_q.robid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single push, contention, backpressure, flush, rdy stall.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk;
    logic rst;
    logic rdy;
    logic flush;
    int   tests;
    int   failed;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cdb(input string tag, input logic [1:0] src, input logic [31:0] val);
        chk({tag, ".valid"}, 64'(bus.cdb_valid), 64'd1);
        chk({tag, ".src"},   64'(bus.cdb_src),   64'(src));
        chk({tag, ".value"}, 64'(bus.cdb_value), 64'(val));
    endtask

    task automatic set_src(input int i, input logic [31:0] v, input logic [ROB_LOG-1:0] r);
        bus.src_value[i*DATA_W +: DATA_W]   = v;
        bus.src_topc[i*DATA_W +: DATA_W]    = NO_JUMP_PC;
        bus.src_robid[i*ROB_LOG +: ROB_LOG] = r;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        rst = 1'b0;
        rdy = 1'b1;
        flush = 1'b0;
        bus.src_valid = '0;
        bus.src_value = '0;
        bus.src_topc  = '0;
        bus.src_robid = '0;

        // Async reset mid-cycle
        #2 rst = 1'b1;
        #1;
        chk("rst.valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst.topc",  64'(bus.cdb_topc),  64'hFFFF_FFFF);
        chk("rst.ready", 64'(bus.src_ready), 64'b111);
        chk("rst.src",   64'(bus.cdb_src),   64'd0);
        tick();
        rst = 1'b0;

        // Single ALU push
        set_src(0, 32'd5, 4'd3);
        bus.src_valid = 3'b001;
        tick();
        bus.src_valid = '0;
        chk("single.e0", 64'(bus.cdb_valid), 64'd0);
        tick();
        chk_cdb("single.e1", 2'd0, 32'd5);
        chk("single.robid", 64'(bus.cdb_robid), 64'd3);
        tick();
        chk("single.e2", 64'(bus.cdb_valid), 64'd0);

        // Fresh reset so source 0 wins the first contention
        rst = 1'b1;
        #1;
        chk("rst2.valid", 64'(bus.cdb_valid), 64'd0);
        #1 rst = 1'b0;

        // Contention: all three push together
        set_src(0, 32'h10, 4'd1);
        set_src(1, 32'h11, 4'd2);
        set_src(2, 32'h12, 4'd4);
        bus.src_valid = 3'b111;
        tick();
        bus.src_valid = '0;
        chk("cont.e0", 64'(bus.cdb_valid), 64'd0);
        chk("cont.ready", 64'(bus.src_ready), 64'b111);
        tick();
        chk_cdb("cont.g0", 2'd0, 32'h10);
        chk("cont.robid0", 64'(bus.cdb_robid), 64'd1);
        tick();
        chk_cdb("cont.g1", 2'd1, 32'h11);
        tick();
        chk_cdb("cont.g2", 2'd2, 32'h12);
        chk("cont.robid2", 64'(bus.cdb_robid), 64'd4);
        set_src(0, 32'h20, 4'd5);
        bus.src_valid = 3'b001;
        tick();
        bus.src_valid = '0;
        chk("cont.idle", 64'(bus.cdb_valid), 64'd0);
        tick();
        chk_cdb("cont.alu", 2'd0, 32'h20);

        // Backpressure on the ALU FIFO while LSB/ST also hold entries
        set_src(0, 32'hA1, 4'd1);
        set_src(1, 32'hB1, 4'd2);
        set_src(2, 32'hC1, 4'd3);
        bus.src_valid = 3'b111;
        tick();
        chk("bp.e1", 64'(bus.cdb_valid), 64'd0);
        set_src(0, 32'hA2, 4'd4);
        set_src(1, 32'hB2, 4'd5);
        bus.src_valid = 3'b011;
        tick();
        chk_cdb("bp.e2", 2'd1, 32'hB1);
        chk("bp.ready.full", 64'(bus.src_ready), 64'b110);
        set_src(0, 32'hA3, 4'd6);
        bus.src_valid = 3'b001;
        tick();
        chk_cdb("bp.e3", 2'd2, 32'hC1);
        chk("bp.ready.still", 64'(bus.src_ready[0]), 64'd0);
        tick();
        chk_cdb("bp.e4", 2'd0, 32'hA1);
        chk("bp.ready.free", 64'(bus.src_ready), 64'b111);
        tick();
        bus.src_valid = '0;
        chk_cdb("bp.e5", 2'd1, 32'hB2);
        tick();
        chk_cdb("bp.e6", 2'd0, 32'hA2);
        tick();
        chk_cdb("bp.e7", 2'd0, 32'hA3);
        chk("bp.robid", 64'(bus.cdb_robid), 64'd6);
        tick();
        chk("bp.e8", 64'(bus.cdb_valid), 64'd0);

        // Flush with two entries queued and a push in the flush cycle
        set_src(0, 32'h50, 4'd1);
        set_src(1, 32'h51, 4'd2);
        set_src(2, 32'h52, 4'd3);
        bus.src_valid = 3'b111;
        tick();
        bus.src_valid = '0;
        chk("fl.e1", 64'(bus.cdb_valid), 64'd0);
        tick();
        chk_cdb("fl.e2", 2'd1, 32'h51);
        flush = 1'b1;
        set_src(0, 32'h5F, 4'd7);
        bus.src_valid = 3'b001;
        tick();
        flush = 1'b0;
        bus.src_valid = '0;
        chk("fl.valid", 64'(bus.cdb_valid), 64'd0);
        chk("fl.ready", 64'(bus.src_ready), 64'b111);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl.after%0d", i), 64'(bus.cdb_valid), 64'd0);
        end

        // rdy stall with queued entries; rr_last is 1 after the flush sequence
        set_src(0, 32'h60, 4'd1);
        set_src(1, 32'h61, 4'd2);
        set_src(2, 32'h62, 4'd3);
        bus.src_valid = 3'b111;
        tick();
        bus.src_valid = '0;
        chk("rdy.e1", 64'(bus.cdb_valid), 64'd0);
        tick();
        chk_cdb("rdy.e2", 2'd2, 32'h62);
        rdy = 1'b0;
        set_src(0, 32'h6F, 4'd7);
        bus.src_valid = 3'b001;
        #1;
        chk("rdy.ready0", 64'(bus.src_ready), 64'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cdb($sformatf("rdy.hold%0d", i), 2'd2, 32'h62);
        end
        rdy = 1'b1;
        bus.src_valid = '0;
        tick();
        chk_cdb("rdy.resume0", 2'd0, 32'h60);
        tick();
        chk_cdb("rdy.resume1", 2'd1, 32'h61);
        tick();
        chk("rdy.drained", 64'(bus.cdb_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
